// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared stack geometry defaults and stack_reader FSM state encoding
package stack_pkg;

    localparam int STACK_DATA_W = 4;
    localparam int STACK_DEPTH  = 8;
    localparam int READER_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        WAIT   = 3'd2,
        HOLD   = 3'd3,
        FINISH = 3'd4
    } reader_state_t;

endpackage

// File: rtl/stack_reader_if.sv
// rtl/stack_reader_if.sv - stack_reader control, stack-side and output-stream signals (optional STACK_READER_PARITY_EN)
interface stack_reader_if #(
    parameter int DATA_W = stack_pkg::STACK_DATA_W,
    parameter int CNT_W  = stack_pkg::READER_CNT_W
);

    logic              start;
    logic [CNT_W-1:0]  max_pops;
    logic              stk_empty;
    logic [DATA_W-1:0] stk_data;
    logic              stk_pop;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  pop_count;
`ifdef STACK_READER_PARITY_EN
    logic              out_parity;
`endif

`ifdef STACK_READER_PARITY_EN
    modport master (
        input  start, max_pops, stk_empty, stk_data, out_ready,
        output stk_pop, out_data, out_valid, busy, done, pop_count, out_parity
    );

    modport slave (
        output start, max_pops, stk_empty, stk_data, out_ready,
        input  stk_pop, out_data, out_valid, busy, done, pop_count, out_parity
    );
`else
    modport master (
        input  start, max_pops, stk_empty, stk_data, out_ready,
        output stk_pop, out_data, out_valid, busy, done, pop_count
    );

    modport slave (
        output start, max_pops, stk_empty, stk_data, out_ready,
        input  stk_pop, out_data, out_valid, busy, done, pop_count
    );
`endif

endinterface

// File: rtl/stack_reader.sv
// rtl/stack_reader.sv - drains a LIFO stack onto a valid/ready stream (optional STACK_READER_PARITY_EN)
module stack_reader #(
    parameter int DATA_W = stack_pkg::STACK_DATA_W,
    parameter int DEPTH  = stack_pkg::STACK_DEPTH,
    parameter int CNT_W  = stack_pkg::READER_CNT_W
) (
    input  logic          clk,
    input  logic          rstN,
    stack_reader_if.master bus
);

    import stack_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    reader_state_t     state;
    reader_state_t     state_next;
    logic [CNT_W-1:0]  limit;
    logic [CNT_W-1:0]  pop_count;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              busy;
    logic              done;
    logic              stk_pop;
    logic              start_ok;
    logic              limit_hit;

    assign start_ok  = (state == IDLE) && bus.start;
    // A zero limit means "until empty"; limits above DEPTH are never reached.
    assign limit_hit = (limit != '0) && (pop_count == limit);

    always_ff @(posedge clk or posedge rstN) begin
        if (rstN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        stk_pop    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_next = POP;
            end
            POP: begin
                if (bus.stk_empty || limit_hit) begin
                    state_next = FINISH;
                end else begin
                    stk_pop    = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                state_next = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) state_next = POP;
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rstN) begin
        if (rstN) begin
            limit     <= '0;
            pop_count <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= (state_next == FINISH);

            if (start_ok) begin
                busy <= 1'b1;
            end else if (state_next == FINISH) begin
                busy <= 1'b0;
            end

            if (start_ok) begin
                limit     <= bus.max_pops;
                pop_count <= '0;
            end else if (stk_pop && (pop_count != CNT_MAX)) begin
                pop_count <= pop_count + CNT_W'(1);
            end

            // The stack presents the popped word one cycle after the strobe.
            if (state == WAIT) begin
                out_data  <= bus.stk_data;
                out_valid <= 1'b1;
            end else if ((state == HOLD) && bus.out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef STACK_READER_PARITY_EN
    logic out_parity;

    always_ff @(posedge clk or posedge rstN) begin
        if (rstN) begin
            out_parity <= 1'b0;
        end else if (state == WAIT) begin
            out_parity <= ^bus.stk_data;
        end
    end

    assign bus.out_parity = out_parity;
`endif

    assign bus.stk_pop   = stk_pop;
    assign bus.out_data  = out_data;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.pop_count = pop_count;

endmodule

// File: doc/stack_reader.md
Name: stack_reader

Overview:
- Consumer-side controller for the 8-deep, 4-bit LIFO `stack`. It is the reader for the stack's push-side writers.
- On a start request it pops the stack until the stack is empty or a pop limit is reached. Each popped word is presented downstream on a valid/ready stream.
- It tracks the pop count and pulses done when finished.
- It sits between `stack` (driving its pop, sampling its data_Out and empty) and any downstream consumer such as a display or UART formatter.

Parameters:
- DATA_W, 4, width of stack words and of out_data.
- DEPTH, 8, stack depth; upper bound for max_pops and the pop counter.
- CNT_W, 4, width of max_pops and pop_count; must hold DEPTH.

Ports:
- clk  input  1  system clock, rising edge.
- rstN  input  1  asynchronous, active-high reset (1 = reset asserted).
- start  input  1  single-cycle request to begin a drain; ignored unless in IDLE.
- max_pops  input  CNT_W  pop limit, sampled on the accepted start; 0 means "until empty".
- stk_empty  input  1  stack empty flag.
- stk_data  input  DATA_W  stack data_Out, valid the cycle after stk_pop.
- stk_pop  output  1  pop strobe to the stack.
- out_data  output  DATA_W  popped word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  downstream accepts the word when out_valid and out_ready are both 1 at a clock edge.
- busy  output  1  drain in progress.
- done  output  1  one-cycle pulse when a drain completes.
- pop_count  output  CNT_W  words popped in the current or last drain.

Behaviour:
- Reset state: all outputs 0 (stk_pop, out_data, out_valid, busy, done, pop_count); FSM goes to IDLE. Reset takes effect immediately, including mid-drain. A word held but unaccepted at reset is discarded and the stack is not restored.
- FSM states: IDLE, POP, WAIT, HOLD, FINISH.
- IDLE
  - On start=1: latch max_pops into limit, clear pop_count, set busy=1, go to POP.
- POP (decision cycle)
  - If stk_empty=1, or (limit≠0 and pop_count==limit): go to FINISH.
  - Otherwise: assert stk_pop for exactly this one cycle, increment pop_count, go to WAIT.
- WAIT
  - Capture stk_data into out_data, set out_valid=1, go to HOLD.
- HOLD
  - Hold out_valid and out_data stable until out_ready=1 at a clock edge.
  - On that handshake: clear out_valid, go to POP.
  - Accept happens no earlier than the cycle after out_valid rises.
- FINISH
  - busy=0, done=1 for one cycle, go to IDLE.
  - pop_count holds its value until the next accepted start.
- Latency and throughput:
  - Start to first stk_pop: 1 cycle.
  - stk_pop to out_valid: 1 cycle.
  - Throughput with out_ready tied high: one word every 3 cycles (POP, WAIT, HOLD).
- stk_pop is never asserted while out_valid=1, so at most one word is ever outstanding and no data can be lost.
- stk_pop is never asserted when stk_empty=1 in the same cycle, so the stack never underflows.
- start during a drain (busy=1) is ignored; no queuing.
- start in the same cycle as the done pulse is ignored, because the FSM is in FINISH, not IDLE.
- Stack empty at start: 0 pops, done two cycles after start (POP, then FINISH), pop_count=0.
- max_pops greater than DEPTH behaves as "until empty".
- pop_count saturates at DEPTH. It can never exceed DEPTH, because the stack goes empty.
- Concurrent pushes by another writer during a drain are legal. Newly pushed words are popped next (LIFO semantics).

Optional Feature:
- Macro: STACK_READER_PARITY_EN.
- Defined: adds output port out_parity (1 bit) = XOR of out_data bits (even parity). It is registered with out_data in WAIT, reset value 0, and valid whenever out_valid=1.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package `stack_pkg` holds:
  - the DATA_W and DEPTH defaults, shared with `stack`;
  - the FSM state enum (IDLE, POP, WAIT, HOLD, FINISH) with explicit 3-bit encoding.
- No sub-module is needed; the output holding register is inline. A generic `sat_counter` for pop_count is optional, not required.

Test Plan:
- Fill the stack with 2,1,2,7,6,9,3,4 (full=1). Pulse start with max_pops=0 and out_ready=1.
  - Required: out_data sequence 4,3,9,6,7,2,1,2; 8 stk_pop pulses; done pulse; pop_count=8; stk_empty=1.
- Same fill, max_pops=3.
  - Required: outputs 4,3,9; done; pop_count=3; stack holds 2,1,2,7,6 with 6 on top.
- Push 1,5 only. Start, with out_ready low for 5 cycles after each out_valid.
  - Required: out_data 5 is stable for 5 cycles, then 1; no stk_pop is issued while out_valid=1.
- Empty stack, start.
  - Required: no stk_pop; done exactly 2 cycles after start; pop_count=0; out_valid stays 0.
- Assert rstN=1 in the HOLD state with out_valid=1 and out_data=7.
  - Required: out_valid, busy and pop_count go to 0 immediately; FSM returns to IDLE; a new start works normally.
- Pulse start again while busy.
  - Required: ignored; pop_count and the output sequence are unaffected.
